// File: rtl/complex_div.sv
// Iterative complex divider z = x / y on IQ-interleaved streams.
// Two time-shared multipliers feed one restoring divider.
module complex_div #(
  parameter int dw = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate_in,
  input  logic                 iq,
  input  logic signed [dw-1:0] x,
  input  logic signed [dw-1:0] y,
  output logic                 busy,
  output logic signed [dw-1:0] z,
  output logic                 gate_out,
  output logic                 iq_out,
  output logic                 div_zero,
  output logic                 sat
);

  localparam int pw = 2 * dw;
  localparam int nw = 2 * dw + 1;
  localparam int cw = $clog2(dw + 1);
  localparam logic [cw-1:0] last = cw'(dw);

  typedef enum logic [2:0] {
    IDLE, GOT_I, MUL1, MUL2, DIV_I, DIV_Q, OUT_I, OUT_Q
  } state_t;

  state_t state;
  logic [cw-1:0] cnt;

  logic signed [dw-1:0] a_r, b_r, c_r, d_r;
  logic signed [pw-1:0] ac, bd, bc, ad, cc, dd;
  logic signed [dw-1:0] m0a, m0b, m1a, m1b;
  logic signed [pw-1:0] m0, m1;
  logic cap_i, cap_q;

  logic signed [nw-1:0] num_i, num_q, den_c;
  logic [nw-1:0] mag_i_c, mag_q_c;
  logic ps_i_c, ps_q_c;

  logic neg_i, neg_q, ps_i, ps_q, dz;
  logic [nw-1:0] mag_q, den_r;

  logic [nw-1:0] rem, rem_nx;
  logic [nw:0] trial;
  logic [dw:0] dsh, q, q_nx;
  logic qbit;
  logic [dw:0] res_i, res_q;

  assign busy  = !(state == IDLE || state == GOT_I);
  assign cap_i = gate_in && iq &&
                 (state == IDLE || state == GOT_I);
  assign cap_q = gate_in && !iq && (state == GOT_I);

  // Operand steering: ac/cc on I, bd/ad on Q, bc/dd in MUL1
  always_comb begin
    m0a = x;
    m0b = y;
    m1a = y;
    m1b = y;
    if (cap_q) begin
      m1a = a_r;
    end else if (state == MUL1) begin
      m0a = b_r;
      m0b = c_r;
      m1a = d_r;
      m1b = d_r;
    end
    m0 = pw'(m0a) * pw'(m0b);
    m1 = pw'(m1a) * pw'(m1b);
  end

  // Numerators, denominator, magnitudes and saturation pre-check
  always_comb begin
    num_i   = nw'(ac) + nw'(bd);
    num_q   = nw'(bc) - nw'(ad);
    den_c   = nw'(cc) + nw'(dd);
    mag_i_c = num_i[nw-1] ? -num_i : num_i;
    mag_q_c = num_q[nw-1] ? -num_q : num_q;
    ps_i_c  = {1'b0, mag_i_c} >= {den_c, 1'b0};
    ps_q_c  = {1'b0, mag_q_c} >= {den_c, 1'b0};
  end

  // One restoring-division step per cycle
  always_comb begin
    trial  = {rem, dsh[dw]} - {1'b0, den_r};
    qbit   = !trial[nw];
    rem_nx = qbit ? trial[nw-1:0]
                  : {rem[nw-2:0], dsh[dw]};
    q_nx   = {q[dw-1:0], qbit};
  end

  function automatic logic [dw:0] fin(
    input logic        neg,
    input logic        ps,
    input logic        dzf,
    input logic [dw:0] qq
  );
    logic [dw:0] lim;
    logic [dw:0] nq;
    logic [dw:0] r;
    lim = '0;
    lim[dw-1] = 1'b1;
    nq = -qq;
    if (dzf) begin
      r = '0;
    end else if (!neg) begin
      if (ps || qq >= lim)
        r = {1'b1, 1'b0, {(dw-1){1'b1}}};
      else
        r = {1'b0, qq[dw-1:0]};
    end else begin
      if (ps || qq > lim)
        r = {1'b1, 1'b1, {(dw-1){1'b0}}};
      else
        r = {1'b0, nq[dw-1:0]};
    end
    return r;
  endfunction

  // Datapath: operand capture, products, divider, results
  always_ff @(posedge clk) begin
    if (cap_i) begin
      a_r <= x;
      c_r <= y;
      ac  <= m0;
      cc  <= m1;
    end
    if (cap_q) begin
      b_r <= x;
      d_r <= y;
      bd  <= m0;
      ad  <= m1;
    end
    if (state == MUL1) begin
      bc <= m0;
      dd <= m1;
    end
    if (state == MUL2) begin
      neg_i <= num_i[nw-1];
      neg_q <= num_q[nw-1];
      ps_i  <= ps_i_c;
      ps_q  <= ps_q_c;
      mag_q <= mag_q_c;
      den_r <= den_c;
      dz    <= (den_c == '0);
      rem   <= mag_i_c >> 2;
      dsh   <= {mag_i_c[1:0], {(dw-1){1'b0}}};
      q     <= '0;
    end
    if (state == DIV_I || state == DIV_Q) begin
      rem <= rem_nx;
      dsh <= {dsh[dw-1:0], 1'b0};
      q   <= q_nx;
    end
    if (state == DIV_I && cnt == last) begin
      res_i <= fin(neg_i, ps_i, dz, q_nx);
      rem   <= mag_q >> 2;
      dsh   <= {mag_q[1:0], {(dw-1){1'b0}}};
      q     <= '0;
    end
    if (state == DIV_Q && cnt == last)
      res_q <= fin(neg_q, ps_q, dz, q_nx);
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      z        <= '0;
      gate_out <= 1'b0;
      iq_out   <= 1'b0;
      div_zero <= 1'b0;
      sat      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gate_in && iq) state <= GOT_I;
        end
        GOT_I: begin
          if (!gate_in)  state <= IDLE;
          else if (!iq)  state <= MUL1;
        end
        MUL1: state <= MUL2;
        MUL2: begin
          state <= DIV_I;
          cnt   <= '0;
        end
        DIV_I: begin
          if (cnt == last) begin
            state <= DIV_Q;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV_Q: begin
          if (cnt == last) begin
            state    <= OUT_I;
            z        <= res_i[dw-1:0];
            sat      <= res_i[dw];
            gate_out <= 1'b1;
            iq_out   <= 1'b1;
            div_zero <= dz;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT_I: begin
          state  <= OUT_Q;
          z      <= res_q[dw-1:0];
          sat    <= res_q[dw];
          iq_out <= 1'b0;
        end
        OUT_Q: begin
          state    <= IDLE;
          gate_out <= 1'b0;
          sat      <= 1'b0;
          div_zero <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// Scoreboard bench for complex_div.
// Reference model uses plain integer complex division.
module tb_complex_div;
  localparam int DW = 18;
  localparam longint HALF = 64'sd1 <<< (DW - 1);

  logic clk = 1'b0;
  logic rst, gate_in, iq;
  logic signed [DW-1:0] x, y, z;
  logic busy, gate_out, iq_out, div_zero, sat;

  complex_div #(.dw(DW)) dut (
    .clk(clk), .rst(rst), .gate_in(gate_in), .iq(iq),
    .x(x), .y(y), .busy(busy), .z(z),
    .gate_out(gate_out), .iq_out(iq_out),
    .div_zero(div_zero), .sat(sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   cyc;
    logic signed [DW-1:0] z;
    logic                 iq;
    logic                 sat;
    logic                 dz;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act,
                     input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0d",
               nm, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void comp(input longint num, input longint den,
                               output logic signed [DW-1:0] zo,
                               output logic so);
    longint m, qq;
    m = (num < 0) ? -num : num;
    qq = (m <<< (DW - 1)) / den;
    if (num >= 0) begin
      if (qq > HALF - 1) begin zo = DW'(HALF - 1); so = 1'b1; end
      else begin zo = DW'(qq); so = 1'b0; end
    end else begin
      if (qq > HALF) begin zo = DW'(-HALF); so = 1'b1; end
      else begin zo = DW'(-qq); so = 1'b0; end
    end
  endfunction

  task automatic push_pair(input longint a, input longint b,
                           input longint c, input longint d,
                           input int n);
    exp_t ei, eq;
    longint den;
    den = c * c + d * d;
    ei.cyc = n + 2 * DW + 5;
    eq.cyc = n + 2 * DW + 6;
    ei.iq = 1'b1;
    eq.iq = 1'b0;
    if (den == 0) begin
      ei.z = '0; ei.sat = 1'b0; ei.dz = 1'b1;
      eq.z = '0; eq.sat = 1'b0; eq.dz = 1'b1;
    end else begin
      comp(a * c + b * d, den, ei.z, ei.sat);
      comp(b * c - a * d, den, eq.z, eq.sat);
      ei.dz = 1'b0;
      eq.dz = 1'b0;
    end
    sbq.push_back(ei);
    sbq.push_back(eq);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) step();
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_wait actual=1 required=0");
    end
  endtask

  task automatic send_pair(input longint a, input longint b,
                           input longint c, input longint d,
                           input bit exp_on, output int n);
    wait_idle();
    gate_in = 1'b1; iq = 1'b1;
    x = DW'(a); y = DW'(c);
    step();
    iq = 1'b0;
    x = DW'(b); y = DW'(d);
    n = cyc;
    step();
    gate_in = 1'b0;
    chk("busy_hi", longint'(busy), 1);
    if (exp_on) push_pair(a, b, c, d, n);
  endtask

  // Monitor: pop and compare whenever the DUT presents a result
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
        total++;
        bad++;
        $display("FAIL missing_out actual=none required_t=%0d",
                 sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (gate_out) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_out actual z=%0d required none t=%0d",
                   z, cyc);
        end else begin
          e = sbq.pop_front();
          chk("latency", cyc, e.cyc);
          chk("z", longint'(z), longint'(e.z));
          chk("iq_out", longint'(iq_out), longint'(e.iq));
          chk("sat", longint'(sat), longint'(e.sat));
          chk("div_zero", longint'(div_zero), longint'(e.dz));
        end
      end
    end
  end

  initial begin
    int n;
    longint a, b, c, d;
    rst = 1'b1; gate_in = 1'b0; iq = 1'b0;
    x = '0; y = '0;
    repeat (3) step();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_z", longint'(z), 0);
    chk("rst_gate", longint'(gate_out), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_dz", longint'(div_zero), 0);
    rst = 1'b0;
    step();

    send_pair(32768, 32768, 65536, 0, 1'b1, n);
    send_pair(65536, 0, 0, 65536, 1'b1, n);
    send_pair(65536, 0, 32768, 0, 1'b1, n);
    send_pair(12345, -777, 0, 0, 1'b1, n);

    // second pair offered while busy is dropped
    send_pair(-40000, 20000, 50000, -30000, 1'b1, n);
    repeat (3) step();
    gate_in = 1'b1; iq = 1'b1; x = 18'sd1000; y = 18'sd2000;
    step();
    iq = 1'b0; x = 18'sd3000; y = 18'sd4000;
    step();
    gate_in = 1'b0;

    // I followed by a gap produces nothing
    wait_idle();
    gate_in = 1'b1; iq = 1'b1; x = 18'sd5000; y = 18'sd6000;
    step();
    gate_in = 1'b0;
    step();
    chk("gap_busy", longint'(busy), 0);
    repeat (4) step();
    chk("gap_busy2", longint'(busy), 0);

    // I, I, Q uses the second I
    wait_idle();
    gate_in = 1'b1; iq = 1'b1; x = 18'sd70000; y = 18'sd9000;
    step();
    x = 18'sd20000; y = -18'sd50000;
    step();
    iq = 1'b0; x = -18'sd10000; y = 18'sd30000;
    n = cyc;
    step();
    gate_in = 1'b0;
    push_pair(20000, -10000, -50000, 30000, n);

    // reset mid-division aborts the pair
    wait_idle();
    repeat (3) step();
    send_pair(30000, 30000, 60000, 10000, 1'b0, n);
    while (cyc < n + 20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_z", longint'(z), 0);
    chk("abort_gate", longint'(gate_out), 0);
    repeat (50) step();
    chk("abort_idle", longint'(busy), 0);

    // random regression
    for (int i = 0; i < 1000; i++) begin
      a = longint'($signed(DW'($urandom))) >>> $urandom_range(0, 6);
      b = longint'($signed(DW'($urandom))) >>> $urandom_range(0, 6);
      do begin
        c = longint'($signed(DW'($urandom))) >>> $urandom_range(0, 4);
        d = longint'($signed(DW'($urandom))) >>> $urandom_range(0, 4);
      end while (c * c + d * d < (64'sd1 <<< 26));
      send_pair(a, b, c, d, 1'b1, n);
    end

    for (int k = 0; k < 300 && sbq.size() > 0; k++) step();
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
